// File: rtl/log_write_sched_pkg.sv
// rtl/log_write_sched_pkg.sv - shared event codes, entry layout and helpers for the log write scheduler
// Purpose: event codes used by the detectors and the log, the 37-bit entry
//          layout, the scheduler FSM state type and the entry builder.
package log_write_sched_pkg;

    localparam int ENTRY_W  = 37;
    localparam int NUM_SRC  = 6;

    // Entry layout: {code[2:0], pc[15:0], addr[15:0], en, wr}
    localparam int CODE_LSB = 34;
    localparam int PC_LSB   = 18;
    localparam int ADDR_LSB = 2;
    localparam int EN_BIT   = 1;
    localparam int WR_BIT   = 0;

    localparam logic [2:0] LOG_X_STACK     = 3'd0;
    localparam logic [2:0] LOG_AC          = 3'd1;
    localparam logic [2:0] LOG_ATOMICITY   = 3'd2;
    localparam logic [2:0] LOG_DMA_AC      = 3'd3;
    localparam logic [2:0] LOG_DMA_DETECT  = 3'd4;
    localparam logic [2:0] LOG_DMA_X_STACK = 3'd5;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    // Builds the snapshot a detector of the given code would log this cycle.
    function automatic logic [ENTRY_W-1:0] make_entry(
        input logic [2:0]  code,
        input logic [15:0] pc,
        input logic [15:0] data_addr,
        input logic        data_en,
        input logic        data_wr,
        input logic [15:0] dma_addr,
        input logic        dma_en
    );
        logic [ENTRY_W-1:0] e;
        logic [15:0]        a;
        logic               en;
        logic               wr;
        case (code)
            LOG_X_STACK: begin
                a = data_addr; en = data_en; wr = data_wr;
            end
            LOG_AC: begin
                a = data_addr; en = data_en; wr = 1'b0;
            end
            LOG_ATOMICITY: begin
                a = 16'h0000; en = 1'b0; wr = 1'b0;
            end
            default: begin
                a = dma_addr; en = dma_en; wr = 1'b0;
            end
        endcase
        e                   = '0;
        e[CODE_LSB +: 3]    = code;
        e[PC_LSB +: 16]     = pc;
        e[ADDR_LSB +: 16]   = a;
        e[EN_BIT]           = en;
        e[WR_BIT]           = wr;
        return e;
    endfunction

endpackage

// File: rtl/log_evt_slot.sv
// rtl/log_evt_slot.sv - one pending-event slot with capture, drain and drop logic
// Purpose: holds one captured log entry until the scheduler drains it.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   cap         event pulse for this slot's source
//   cap_data    snapshot to store on capture
//   drain       scheduler is consuming (writing or discarding) this slot now
//   pend        slot holds an entry
//   data        stored entry
//   drop        pulse: event arrived while slot still occupied and not drained
module log_evt_slot
    import log_write_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cap,
    input  logic [ENTRY_W-1:0] cap_data,
    input  logic               drain,
    output logic               pend,
    output logic [ENTRY_W-1:0] data,
    output logic               drop
);

    logic               pend_q, pend_d;
    logic [ENTRY_W-1:0] data_q, data_d;

    always_comb begin
        pend_d = pend_q;
        data_d = data_q;
        drop   = 1'b0;
        if (drain) begin
            pend_d = 1'b0;
        end
        // A drain in the same cycle frees the slot, so the new event fits.
        if (cap) begin
            if (pend_q && !drain) begin
                drop = 1'b1;
            end else begin
                pend_d = 1'b1;
                data_d = cap_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign pend = pend_q;
    assign data = data_q;

endmodule

// File: rtl/log_write_sched.sv
// rtl/log_write_sched.sv - violation-log RAM write scheduler with per-source slots and clear sweep
// Purpose: captures violation pulses into six slots, drains them to the log
//          RAM one per cycle (lowest code first), tracks pointer/count/status,
//          and sweeps the RAM to zero on clr_req.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   ev_req[5:0]                      violation pulses, bit i = code i
//   pc, data_addr, data_en, data_wr  CPU snapshot
//   dma_addr, dma_en                 DMA snapshot
//   clr_req                          one-cycle clear request
//   ram_we, ram_wr_addr, ram_wr_data registered RAM write port
//   busy                             clear sweep in progress
//   pend                             slot pending flags
//   full, wrapped, overflow          status (full for WRAP=0, wrapped for WRAP=1)
//   entry_cnt                        entries since last clear, saturating
module log_write_sched
    import log_write_sched_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter bit WRAP   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         ev_req,
    input  logic [15:0]        pc,
    input  logic [15:0]        data_addr,
    input  logic               data_en,
    input  logic               data_wr,
    input  logic [15:0]        dma_addr,
    input  logic               dma_en,
    input  logic               clr_req,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_wr_addr,
    output logic [ENTRY_W-1:0] ram_wr_data,
    output logic               busy,
    output logic [5:0]         pend,
    output logic               full,
    output logic               wrapped,
    output logic               overflow,
    output logic [ADDR_W:0]    entry_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    logic [ENTRY_W-1:0] snap      [NUM_SRC];
    logic [ENTRY_W-1:0] slot_data [NUM_SRC];
    logic [5:0]         slot_pend;
    logic [5:0]         slot_drop;
    logic [5:0]         drain;

    logic [2:0]         sel;
    logic               any_pend;
    logic [ENTRY_W-1:0] sel_data;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wptr_q, wptr_d;
    logic [ADDR_W-1:0]  swp_q, swp_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               wrapped_q, wrapped_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [ENTRY_W-1:0] ram_data_q, ram_data_d;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            snap[i] = make_entry(3'(i), pc, data_addr, data_en, data_wr, dma_addr, dma_en);
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        log_evt_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .cap      (ev_req[g]),
            .cap_data (snap[g]),
            .drain    (drain[g]),
            .pend     (slot_pend[g]),
            .data     (slot_data[g]),
            .drop     (slot_drop[g])
        );
    end

    // Lowest pending index wins; scanning downward leaves the lowest last.
    always_comb begin
        sel      = 3'd0;
        any_pend = 1'b0;
        sel_data = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (slot_pend[i]) begin
                sel      = 3'(i);
                any_pend = 1'b1;
                sel_data = slot_data[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        swp_d      = swp_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        wrapped_d  = wrapped_q;
        ovf_d      = ovf_q | (|slot_drop);
        busy_d     = busy_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = '0;
        drain      = 6'b000000;
        case (state_q)
            ST_IDLE: begin
                // Clear takes priority; pending slots stay put for later.
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    busy_d     = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = '0;
                    swp_d      = '0;
                end else if (any_pend) begin
                    drain = 6'b000001 << sel;
                    if (full_q) begin
                        // No room: the selected entry is thrown away.
                        ovf_d = 1'b1;
                    end else begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = wptr_q;
                        ram_data_d = sel_data;
                        wptr_d     = wptr_q + ADDR_W'(1);
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                        end
                        if (wptr_q == ADDR_MAX) begin
                            if (WRAP) begin
                                wrapped_d = 1'b1;
                            end else begin
                                full_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_CLEAR: begin
                if (swp_q == ADDR_MAX) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    wptr_d    = '0;
                    cnt_d     = '0;
                    full_d    = 1'b0;
                    wrapped_d = 1'b0;
                    // A drop on the final sweep cycle is still a real loss.
                    ovf_d     = |slot_drop;
                end else begin
                    swp_d      = swp_q + ADDR_W'(1);
                    ram_we_d   = 1'b1;
                    ram_addr_d = swp_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            swp_q      <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            wrapped_q  <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            swp_q      <= swp_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            wrapped_q  <= wrapped_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign ram_we      = ram_we_q;
    assign ram_wr_addr = ram_addr_q;
    assign ram_wr_data = ram_data_q;
    assign busy        = busy_q;
    assign pend        = slot_pend;
    assign full        = full_q;
    assign wrapped     = wrapped_q;
    assign overflow    = ovf_q;
    assign entry_cnt   = cnt_q;

endmodule

// File: tb/tb_log_write_sched.sv
// tb/tb_log_write_sched.sv - directed self-checking bench for log_write_sched
module tb_log_write_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  ev_req = '0;
    logic [15:0] pc = '0, data_addr = '0, dma_addr = '0;
    logic        data_en = 1'b0, data_wr = 1'b0, dma_en = 1'b0, clr_req = 1'b0;

    logic        ram_we, busy, full, wrapped, overflow;
    logic [3:0]  ram_wr_addr;
    logic [36:0] ram_wr_data;
    logic [5:0]  pend;
    logic [4:0]  entry_cnt;

    logic        n_ram_we, n_busy, n_full, n_wrapped, n_overflow;
    logic [3:0]  n_ram_wr_addr;
    logic [36:0] n_ram_wr_data;
    logic [5:0]  n_pend;
    logic [4:0]  n_entry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    log_write_sched #(.ADDR_W(4), .WRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .ev_req(ev_req), .pc(pc), .data_addr(data_addr),
        .data_en(data_en), .data_wr(data_wr), .dma_addr(dma_addr), .dma_en(dma_en),
        .clr_req(clr_req), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .busy(busy), .pend(pend), .full(full),
        .wrapped(wrapped), .overflow(overflow), .entry_cnt(entry_cnt)
    );

    log_write_sched #(.ADDR_W(4), .WRAP(1'b0)) dut_nowrap (
        .clk(clk), .reset(reset), .ev_req(ev_req), .pc(pc), .data_addr(data_addr),
        .data_en(data_en), .data_wr(data_wr), .dma_addr(dma_addr), .dma_en(dma_en),
        .clr_req(clr_req), .ram_we(n_ram_we), .ram_wr_addr(n_ram_wr_addr),
        .ram_wr_data(n_ram_wr_data), .busy(n_busy), .pend(n_pend), .full(n_full),
        .wrapped(n_wrapped), .overflow(n_overflow), .entry_cnt(n_entry_cnt)
    );

    typedef struct {
        logic [5:0]  ev;
        logic [15:0] pc;
        logic [15:0] daddr;
        logic        den;
        logic        dwr;
        logic [15:0] dma;
        logic        dmaen;
        logic [36:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int found;

        vecs[0] = '{6'b000010, 16'h1234, 16'h0200, 1'b1, 1'b0, 16'h3333, 1'b1,
                    {3'd1, 16'h1234, 16'h0200, 1'b1, 1'b0}};
        vecs[1] = '{6'b000001, 16'h1111, 16'h2222, 1'b1, 1'b1, 16'h3333, 1'b1,
                    {3'd0, 16'h1111, 16'h2222, 1'b1, 1'b1}};
        vecs[2] = '{6'b000100, 16'hABCD, 16'hFFFF, 1'b1, 1'b1, 16'h3333, 1'b1,
                    {3'd2, 16'hABCD, 16'h0000, 1'b0, 1'b0}};
        vecs[3] = '{6'b001000, 16'h0001, 16'h2222, 1'b1, 1'b1, 16'h4321, 1'b1,
                    {3'd3, 16'h0001, 16'h4321, 1'b1, 1'b0}};
        vecs[4] = '{6'b010000, 16'h0002, 16'h2222, 1'b1, 1'b1, 16'h8765, 1'b0,
                    {3'd4, 16'h0002, 16'h8765, 1'b0, 1'b0}};
        vecs[5] = '{6'b100000, 16'hFFFF, 16'h2222, 1'b0, 1'b1, 16'h0000, 1'b1,
                    {3'd5, 16'hFFFF, 16'h0000, 1'b1, 1'b0}};

        do_reset();
        chk("rst_we",    64'(ram_we), 64'd0);
        chk("rst_addr",  64'(ram_wr_addr), 64'd0);
        chk("rst_data",  64'(ram_wr_data), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_pend",  64'(pend), 64'd0);
        chk("rst_full",  64'(full), 64'd0);
        chk("rst_wrap",  64'(wrapped), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_cnt",   64'(entry_cnt), 64'd0);

        // Single events, one code each, written at consecutive addresses.
        for (int i = 0; i < 6; i++) begin
            ev_req = vecs[i].ev; pc = vecs[i].pc; data_addr = vecs[i].daddr;
            data_en = vecs[i].den; data_wr = vecs[i].dwr;
            dma_addr = vecs[i].dma; dma_en = vecs[i].dmaen;
            tick();
            ev_req = '0;
            tick();
            chk($sformatf("vec%0d_we", i),   64'(ram_we), 64'd1);
            chk($sformatf("vec%0d_addr", i), 64'(ram_wr_addr), 64'(i));
            chk($sformatf("vec%0d_data", i), 64'(ram_wr_data), 64'(vecs[i].exp));
            tick();
            chk($sformatf("vec%0d_idle_we", i),   64'(ram_we), 64'd0);
            chk($sformatf("vec%0d_idle_data", i), 64'(ram_wr_data), 64'd0);
        end
        chk("vec_cnt", 64'(entry_cnt), 64'd6);

        // Coincident events drain lowest code first.
        do_reset();
        ev_req = 6'b100101;
        tick();
        ev_req = '0;
        chk("coin_pend", 64'(pend), 64'h25);
        tick();
        chk("coin0_addr", 64'(ram_wr_addr), 64'd0);
        chk("coin0_code", 64'(ram_wr_data[36:34]), 64'd0);
        tick();
        chk("coin1_addr", 64'(ram_wr_addr), 64'd1);
        chk("coin1_code", 64'(ram_wr_data[36:34]), 64'd2);
        tick();
        chk("coin2_we",   64'(ram_we), 64'd1);
        chk("coin2_addr", 64'(ram_wr_addr), 64'd2);
        chk("coin2_code", 64'(ram_wr_data[36:34]), 64'd5);
        chk("coin_ovf",   64'(overflow), 64'd0);

        // Back-to-back code-3 events while code 0 is draining first.
        do_reset();
        ev_req = 6'b001001;
        tick();
        ev_req = 6'b001000;
        tick();
        ev_req = '0;
        chk("drop_ovf", 64'(overflow), 64'd1);
        tick();
        tick();
        chk("drop_cnt",  64'(entry_cnt), 64'd2);
        chk("drop_pend", 64'(pend), 64'd0);

        // 17 consecutive events: wrap vs. stop-when-full.
        do_reset();
        ev_req = 6'b000001;
        for (int i = 0; i < 17; i++) tick();
        ev_req = '0;
        tick();
        chk("wrap_we",      64'(ram_we), 64'd1);
        chk("wrap_addr",    64'(ram_wr_addr), 64'd0);
        chk("wrap_flag",    64'(wrapped), 64'd1);
        chk("wrap_cnt",     64'(entry_cnt), 64'd16);
        chk("wrap_ovf",     64'(overflow), 64'd0);
        chk("nowrap_full",  64'(n_full), 64'd1);
        chk("nowrap_ovf",   64'(n_overflow), 64'd1);
        chk("nowrap_we",    64'(n_ram_we), 64'd0);
        chk("nowrap_cnt",   64'(n_entry_cnt), 64'd16);
        chk("nowrap_pend",  64'(n_pend), 64'd0);

        // Clear with a coincident code-2 event; status from above must clear.
        clr_req = 1'b1;
        ev_req = 6'b000100;
        pc = 16'h5A5A;
        tick();
        clr_req = 1'b0;
        ev_req = '0;
        chk("clr_pend", 64'(pend), 64'h04);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("clr%0d_busy", k), 64'(busy), 64'd1);
            chk($sformatf("clr%0d_we", k),   64'(ram_we), 64'd1);
            chk($sformatf("clr%0d_addr", k), 64'(ram_wr_addr), 64'(k));
            chk($sformatf("clr%0d_data", k), 64'(ram_wr_data), 64'd0);
            tick();
        end
        chk("clr_done_busy", 64'(busy), 64'd0);
        chk("clr_wrap",      64'(wrapped), 64'd0);
        chk("clr_nfull",     64'(n_full), 64'd0);
        chk("clr_novf",      64'(n_overflow), 64'd0);
        found = 0;
        for (int t = 0; t < 4 && found == 0; t++) begin
            if (ram_we) found = 1;
            else tick();
        end
        chk("post_clr_seen", 64'(found), 64'd1);
        chk("post_clr_addr", 64'(ram_wr_addr), 64'd0);
        chk("post_clr_data", 64'(ram_wr_data), 64'({3'd2, 16'h5A5A, 16'h0000, 1'b0, 1'b0}));
        chk("post_clr_cnt",  64'(entry_cnt), 64'd1);

        // Reset in the middle of a sweep.
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        chk("mid_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_we",   64'(ram_we), 64'd0);
        chk("abort_addr", 64'(ram_wr_addr), 64'd0);
        chk("abort_cnt",  64'(entry_cnt), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_idle_busy", 64'(busy), 64'd0);
        chk("abort_idle_we",   64'(ram_we), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
